ram_access_ctrl: RTL and testbench

Front-end controller that sits directly upstream of the 1K x 8 single-port RAM and owns its address/write/data_in pins. It accepts independent valid/ready write and read request streams, arbitrates them round-robin onto the single port, and tracks each read through the RAM's one-cycle registered output. Read data is returned in request order on a valid/ready response stream backed by a 2-entry buffer, so response backpressure never drops data.

---
 rtl/ram_access_ctrl.sv | 130 +++++++++++++
 tb/tb_ram_access_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - round-robin write/read front end for a 1K x 8 single-port RAM
module ram_access_ctrl #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int RSP_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_wr_valid,
    output logic              o_wr_ready,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_valid,
    output logic              o_rd_ready,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic [ADDR_W-1:0] o_ram_address,
    output logic              o_ram_write,
    output logic [DATA_W-1:0] o_ram_data_in,
    input  logic [DATA_W-1:0] i_ram_data_out
);

    typedef enum logic {
        GRANT_WRITE = 1'b0,
        GRANT_READ  = 1'b1
    } grant_t;

    grant_t              r_last_grant;
    grant_t              w_last_grant_next;
    logic                w_wr_grant;
    logic                w_rd_grant;
    logic                w_rd_credit;
    logic [2:0]          w_credit_sum;
    logic                w_push;
    logic                w_pop;

    logic                r_rd_inflight;
    logic [DATA_W-1:0]   r_fifo [2];
    logic                r_wptr;
    logic                r_rptr;
    logic [1:0]          r_count;
    logic [ADDR_W-1:0]   r_ram_address;
    logic [DATA_W-1:0]   r_ram_data_in;

    assign w_pop        = o_rsp_valid && i_rsp_ready;
    assign w_push       = r_rd_inflight;
    // Occupancy the buffer will have once the inflight read lands; a new read needs a free slot.
    assign w_credit_sum = {1'b0, r_count} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
    assign w_rd_credit  = w_credit_sum < 3'(RSP_DEPTH);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant <= GRANT_READ;
        end else begin
            r_last_grant <= w_last_grant_next;
        end
    end

    always_comb begin
        w_wr_grant        = 1'b0;
        w_rd_grant        = 1'b0;
        w_last_grant_next = r_last_grant;
        if (!i_reset) begin
            if (i_wr_valid && i_rd_valid && w_rd_credit) begin
                if (r_last_grant == GRANT_READ) begin
                    w_wr_grant = 1'b1;
                end else begin
                    w_rd_grant = 1'b1;
                end
            end else if (i_wr_valid) begin
                w_wr_grant = 1'b1;
            end else if (i_rd_valid && w_rd_credit) begin
                w_rd_grant = 1'b1;
            end
        end
        if (w_wr_grant) begin
            w_last_grant_next = GRANT_WRITE;
        end else if (w_rd_grant) begin
            w_last_grant_next = GRANT_READ;
        end
    end

    assign o_wr_ready    = w_wr_grant;
    assign o_rd_ready    = w_rd_grant;
    assign o_ram_write   = w_wr_grant;
    assign o_ram_address = w_wr_grant ? i_wr_addr : (w_rd_grant ? i_rd_addr : r_ram_address);
    assign o_ram_data_in = w_wr_grant ? i_wr_data : r_ram_data_in;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_ram_address <= '0;
            r_ram_data_in <= '0;
        end else begin
            r_ram_address <= o_ram_address;
            r_ram_data_in <= o_ram_data_in;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd_inflight <= 1'b0;
            r_fifo[0]     <= '0;
            r_fifo[1]     <= '0;
            r_wptr        <= 1'b0;
            r_rptr        <= 1'b0;
            r_count       <= 2'd0;
        end else begin
            assert (!(w_push && r_count == 2'd2));
            r_rd_inflight <= w_rd_grant;
            if (w_push) begin
                r_fifo[r_wptr] <= i_ram_data_out;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_rsp_valid = r_count != 2'd0;
    assign o_rsp_data  = r_fifo[r_rptr];

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed scoreboard bench for ram_access_ctrl with a behavioral RAM
module tb_ram_access_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_valid, wr_ready, rd_valid, rd_ready, rsp_valid, rsp_ready;
    logic [9:0] wr_addr, rd_addr, ram_address;
    logic [7:0] wr_data, rsp_data, ram_data_in, ram_data_out;
    logic       ram_write;

    always #5 clk = ~clk;

    ram_access_ctrl dut (
        .i_clk          (clk),
        .i_reset        (reset),
        .i_wr_valid     (wr_valid),
        .o_wr_ready     (wr_ready),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_rd_valid     (rd_valid),
        .o_rd_ready     (rd_ready),
        .i_rd_addr      (rd_addr),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_data     (rsp_data),
        .o_ram_address  (ram_address),
        .o_ram_write    (ram_write),
        .o_ram_data_in  (ram_data_in),
        .i_ram_data_out (ram_data_out)
    );

    logic [7:0] ram_mem [1024];
    always @(posedge clk) begin
        if (reset) begin
            foreach (ram_mem[i]) ram_mem[i] <= 8'h00;
            ram_data_out <= 8'h00;
        end else begin
            if (ram_write) ram_mem[ram_address] <= ram_data_in;
            ram_data_out <= ram_mem[ram_address];
        end
    end

    logic [7:0] shadow [1024];
    logic [7:0] sb [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         pop_cnt = 0;
    int         rd_acc_cnt = 0;
    logic       s_wr_ready, s_rd_ready, s_rsp_valid, s_ram_write;
    logic [7:0] s_rsp_data, s_ram_data_in, s_last_rsp;
    logic [9:0] s_ram_address;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        s_wr_ready    = wr_ready;
        s_rd_ready    = rd_ready;
        s_rsp_valid   = rsp_valid;
        s_rsp_data    = rsp_data;
        s_ram_write   = ram_write;
        s_ram_address = ram_address;
        s_ram_data_in = ram_data_in;
        if (reset) begin
            sb.delete();
            foreach (shadow[i]) shadow[i] = 8'h00;
        end else begin
            if (wr_valid && wr_ready) shadow[wr_addr] = wr_data;
            if (rd_valid && rd_ready) begin
                sb.push_back(shadow[rd_addr]);
                rd_acc_cnt++;
            end
            if (rsp_valid && rsp_ready) begin
                pop_cnt++;
                s_last_rsp = rsp_data;
                if (sb.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
                else chk("rsp_data", {24'd0, rsp_data}, {24'd0, sb.pop_front()});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        rsp_ready = 1'b1;
        while ((sb.size() != 0 || rsp_valid) && k < 50) begin
            tick();
            k++;
        end
        chk("drain_empty", sb.size(), 32'd0);
    endtask

    task automatic do_write(input logic [9:0] a, input logic [7:0] d);
        int k = 0;
        wr_valid = 1'b1; wr_addr = a; wr_data = d;
        do begin tick(); k++; end while (!s_wr_ready && k < 20);
        chk("wr_accept", {31'd0, s_wr_ready}, 32'd1);
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [9:0] a);
        int k = 0;
        rd_valid = 1'b1; rd_addr = a;
        do begin tick(); k++; end while (!s_rd_ready && k < 20);
        chk("rd_accept", {31'd0, s_rd_ready}, 32'd1);
        rd_valid = 1'b0;
    endtask

    initial begin
        int p0;
        int a0;
        foreach (shadow[i]) shadow[i] = 8'h00;
        reset = 1'b1; wr_valid = 1'b1; rd_valid = 1'b1; rsp_ready = 1'b0;
        wr_addr = 10'h155; wr_data = 8'h77; rd_addr = 10'h0AA;
        tick(); tick();
        chk("reset_wr_ready", {31'd0, s_wr_ready}, 32'd0);
        chk("reset_rd_ready", {31'd0, s_rd_ready}, 32'd0);
        chk("reset_rsp_valid", {31'd0, s_rsp_valid}, 32'd0);
        chk("reset_rsp_data", {24'd0, s_rsp_data}, 32'd0);
        chk("reset_ram_write", {31'd0, s_ram_write}, 32'd0);
        chk("reset_ram_address", {22'd0, s_ram_address}, 32'd0);
        chk("reset_ram_data_in", {24'd0, s_ram_data_in}, 32'd0);
        reset = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;

        // single write then read, with latency check
        wr_valid = 1'b1; wr_addr = 10'h003; wr_data = 8'hA5;
        tick();
        chk("first_wr_ready", {31'd0, s_wr_ready}, 32'd1);
        wr_valid = 1'b0;
        rd_valid = 1'b1; rd_addr = 10'h003; rsp_ready = 1'b1;
        tick();
        chk("first_rd_ready", {31'd0, s_rd_ready}, 32'd1);
        rd_valid = 1'b0;
        tick();
        chk("lat_n1_rsp_valid", {31'd0, s_rsp_valid}, 32'd0);
        tick();
        chk("lat_n2_rsp_valid", {31'd0, s_rsp_valid}, 32'd1);
        chk("lat_n2_rsp_data", {24'd0, s_rsp_data}, 32'hA5);
        drain();

        // top address write, address 0 unaffected
        do_write(10'h3FF, 8'h3C);
        do_read(10'h3FF);
        drain();
        chk("top_addr_data", {24'd0, s_last_rsp}, 32'h3C);
        do_read(10'h000);
        drain();
        chk("addr0_untouched", {24'd0, s_last_rsp}, 32'h00);

        // 8 writes then 8 back-to-back reads
        for (int i = 0; i < 8; i++) do_write(10'(i), 8'(8'h11 + i));
        rsp_ready = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 8; i++) begin
            rd_valid = 1'b1; rd_addr = 10'(i);
            tick();
            chk("b2b_rd_ready", {31'd0, s_rd_ready}, 32'd1);
        end
        rd_valid = 1'b0;
        tick(); tick();
        chk("b2b_pop_count", 32'(pop_cnt - p0), 32'd8);
        chk("b2b_sb_empty", sb.size(), 32'd0);

        // contention: alternating grants, read-after-write
        for (int k = 0; k < 6; k++) begin
            wr_valid = 1'b1; wr_addr = 10'(10'h020 + k / 2); wr_data = 8'(8'h40 + k / 2);
            rd_valid = 1'b1; rd_addr = 10'(10'h020 + k / 2);
            if (k % 2 == 1) wr_addr = 10'(10'h020 + k / 2 + 1);
            if (k % 2 == 1) wr_data = 8'(8'h40 + k / 2 + 1);
            tick();
            chk("alt_wr_ready", {31'd0, s_wr_ready}, 32'(k % 2 == 0));
            chk("alt_rd_ready", {31'd0, s_rd_ready}, 32'(k % 2 == 1));
        end
        wr_valid = 1'b0; rd_valid = 1'b0;
        drain();
        chk("alt_last_rsp", {24'd0, s_last_rsp}, 32'h42);

        // backpressure: only two reads accepted while rsp_ready is low
        rsp_ready = 1'b0;
        a0 = rd_acc_cnt;
        p0 = pop_cnt;
        rd_valid = 1'b1; rd_addr = 10'h000;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (s_rd_ready) rd_addr = rd_addr + 10'd1;
        end
        chk("bp_accepts", 32'(rd_acc_cnt - a0), 32'd2);
        chk("bp_rd_ready_low", {31'd0, s_rd_ready}, 32'd0);
        rsp_ready = 1'b1;
        for (int k = 0; k < 20 && rd_acc_cnt - a0 < 6; k++) begin
            tick();
            if (s_rd_ready) rd_addr = rd_addr + 10'd1;
        end
        rd_valid = 1'b0;
        chk("bp_resume_accepts", 32'(rd_acc_cnt - a0), 32'd6);
        drain();
        chk("bp_pops", 32'(pop_cnt - p0), 32'd6);

        // reset with one read buffered and one inflight
        rsp_ready = 1'b0;
        rd_valid = 1'b1; rd_addr = 10'h003;
        tick(); tick();
        rd_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        chk("post_reset_rsp_valid", {31'd0, s_rsp_valid}, 32'd0);
        p0 = pop_cnt;
        rsp_ready = 1'b1;
        tick(); tick(); tick();
        chk("post_reset_no_pops", 32'(pop_cnt - p0), 32'd0);
        do_read(10'h003);
        drain();
        chk("post_reset_read_zero", {24'd0, s_last_rsp}, 32'h00);
        chk("post_reset_pops", 32'(pop_cnt - p0), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
